// File: rtl/sprite_anim_renderer.sv
// Sprite pixel pipeline: per-frame latched geometry, shared frame ROM addressing, colour key, hit flash.
// Latency: hcount/vcount sampled at cycle N -> sprite_on/sprite_rgb valid at N+3+ROM_LAT.
// Backpressure: none; accepts one pixel per cycle, never stalls.
module sprite_anim_renderer #(
  parameter int          SPR_W        = 126,
  parameter int          SPR_H        = 126,
  parameter int          NUM_FRAMES   = 36,
  parameter int          ADDR_W       = 20,
  parameter int          ROM_LAT      = 1,
  parameter logic [11:0] KEY_RGB      = 12'h000,
  parameter logic [11:0] FLASH_RGB    = 12'hFFF,
  parameter int          FLASH_FRAMES = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [9:0]                    hcount,
  input  logic [9:0]                    vcount,
  input  logic                          frame_start,
  input  logic [9:0]                    pos_x,
  input  logic [9:0]                    pos_y,
  input  logic                          facing_right,
  input  logic [$clog2(NUM_FRAMES)-1:0] frame_idx,
  input  logic                          hit,
  output logic [ADDR_W-1:0]             rom_addr,
  input  logic [11:0]                   rom_data,
  output logic                          sprite_on,
  output logic [11:0]                   sprite_rgb
);

  localparam int IDX_W    = $clog2(NUM_FRAMES);
  localparam int ROW_W    = $clog2(SPR_H);
  localparam int COL_W    = $clog2(SPR_W);
  localparam int FRAME_SZ = SPR_W * SPR_H;

  // Shadow geometry, held constant for a whole video frame
  logic [9:0]        r_px;
  logic [9:0]        r_py;
  logic              r_facing;
  logic [IDX_W-1:0]  r_idx;
  logic [ADDR_W-1:0] r_base;

  // Pixel pipeline
  logic              r_inside_a;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_inside_b;
  logic [ROM_LAT-1:0] r_in_pipe;
  logic              r_sprite_on;
  logic [11:0]       r_sprite_rgb;

  // Flash effect
  logic [7:0]        r_flash_cnt;
  logic              r_flash_act;

  // Bounding box compared at 11 bits so px+SPR_W past 1023 cannot wrap to a false hit near 0
  logic [10:0]       w_h11;
  logic [10:0]       w_v11;
  logic [10:0]       w_px_end;
  logic [10:0]       w_py_end;
  logic              w_inside;
  logic              w_idx_ok;
  logic [COL_W-1:0]  w_col_eff;
  logic [ADDR_W-1:0] w_pix_addr;
  logic              w_opaque;
  logic              w_flash_now;

  assign w_h11       = {1'b0, hcount};
  assign w_v11       = {1'b0, vcount};
  assign w_px_end    = {1'b0, r_px} + 11'(SPR_W);
  assign w_py_end    = {1'b0, r_py} + 11'(SPR_H);
  assign w_inside    = (w_h11 >= {1'b0, r_px}) && (w_h11 < w_px_end) &&
                       (w_v11 >= {1'b0, r_py}) && (w_v11 < w_py_end);
  assign w_idx_ok    = (32'(frame_idx) < NUM_FRAMES);
  assign w_col_eff   = r_facing ? r_col : (COL_W'(SPR_W - 1) - r_col);
  assign w_pix_addr  = r_base + ADDR_W'(r_row) * ADDR_W'(SPR_W) + ADDR_W'(w_col_eff);
  assign w_opaque    = r_in_pipe[ROM_LAT-1] && (rom_data != KEY_RGB);
  assign w_flash_now = (r_flash_cnt != 8'd0) && r_flash_cnt[1];

  // Capture geometry only on frame_start; out-of-range frame indices fall back to frame 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_px     <= '0;
      r_py     <= '0;
      r_facing <= 1'b1;
      r_idx    <= '0;
    end else if (frame_start) begin
      r_px     <= pos_x;
      r_py     <= pos_y;
      r_facing <= facing_right;
      r_idx    <= w_idx_ok ? frame_idx : '0;
    end
  end

  // Frame base address, one constant multiply registered off the shadow index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_base <= '0;
    else     r_base <= ADDR_W'(r_idx) * ADDR_W'(FRAME_SZ);
  end

  // Stage A: box test and sprite-relative row/column
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inside_a <= 1'b0;
      r_row      <= '0;
      r_col      <= '0;
    end else begin
      r_inside_a <= w_inside;
      r_row      <= ROW_W'(vcount - r_py);
      r_col      <= COL_W'(hcount - r_px);
    end
  end

  // Stage B: ROM address (mirrored column when facing left); outside the box park on base
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rom_addr <= '0;
      r_inside_b <= 1'b0;
    end else begin
      r_rom_addr <= r_inside_a ? w_pix_addr : r_base;
      r_inside_b <= r_inside_a;
    end
  end

  // Delay the inside flag to line up with the ROM word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_pipe <= '0;
    end else begin
      r_in_pipe[0] <= r_inside_b;
      for (int k = 1; k < ROM_LAT; k++) r_in_pipe[k] <= r_in_pipe[k-1];
    end
  end

  // Flash counter: hit (re)loads, frame_start counts down; active bit frozen per video frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flash_cnt <= 8'd0;
      r_flash_act <= 1'b0;
    end else begin
      if (frame_start) r_flash_act <= w_flash_now;
      if (hit)                                     r_flash_cnt <= 8'(FLASH_FRAMES);
      else if (frame_start && r_flash_cnt != 8'd0) r_flash_cnt <= r_flash_cnt - 8'd1;
    end
  end

  // Output stage: colour key, flash substitution, black when not drawn
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sprite_on  <= 1'b0;
      r_sprite_rgb <= 12'h000;
    end else begin
      r_sprite_on  <= w_opaque;
      r_sprite_rgb <= w_opaque ? (r_flash_act ? FLASH_RGB : rom_data) : 12'h000;
    end
  end

  assign rom_addr   = r_rom_addr;
  assign sprite_on  = r_sprite_on;
  assign sprite_rgb = r_sprite_rgb;

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Bench for sprite_anim_renderer: behavioural model of box, addressing, colour key and flash.
// Latency: probes wait 2 cycles for rom_addr and 3+ROM_LAT cycles for pixel outputs.
// Backpressure: not applicable; the bench drives one pixel coordinate at a time.
module tb_sprite_anim_renderer;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  hcount, vcount, pos_x, pos_y;
  logic        frame_start, facing_right, hit;
  logic [5:0]  frame_idx;
  logic [19:0] rom_addr;
  logic [11:0] rom_data;
  logic        sprite_on;
  logic [11:0] sprite_rgb;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int m_px, m_py, m_idx, m_cnt;
  bit m_face, m_act;
  int rom_mode;

  logic [11:0] rom_pipe [LAT];

  always #5 clk = ~clk;

  sprite_anim_renderer #(.ROM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .frame_start(frame_start),
    .pos_x(pos_x), .pos_y(pos_y), .facing_right(facing_right), .frame_idx(frame_idx),
    .hit(hit), .rom_addr(rom_addr), .rom_data(rom_data), .sprite_on(sprite_on),
    .sprite_rgb(sprite_rgb)
  );

  // ROM contents: mode 0 pattern with every 4th word transparent, mode 1 all key, mode 2 all green
  function automatic logic [11:0] rom_fn(input int a);
    if (rom_mode == 1) return 12'h000;
    if (rom_mode == 2) return 12'h0F0;
    if (a % 4 == 3) return 12'h000;
    return 12'((a * 37 + 5) % 4096);
  endfunction

  always @(posedge clk) begin
    rom_pipe[0] <= rom_fn(int'(rom_addr));
    for (int k = 1; k < LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
  end
  assign rom_data = rom_pipe[LAT-1];

  function automatic bit m_inside(input int h, input int v);
    return (h >= m_px) && (h < m_px + 126) && (v >= m_py) && (v < m_py + 126);
  endfunction

  function automatic int m_addr(input int h, input int v);
    int base;
    base = m_idx * 126 * 126;
    if (!m_inside(h, v)) return base;
    return base + (v - m_py) * 126 + (m_face ? (h - m_px) : (125 - (h - m_px)));
  endfunction

  function automatic bit m_on(input int h, input int v);
    return m_inside(h, v) && (rom_fn(m_addr(h, v)) != 12'h000);
  endfunction

  function automatic logic [11:0] m_rgb(input int h, input int v);
    if (!m_on(h, v)) return 12'h000;
    return m_act ? 12'hFFF : rom_fn(m_addr(h, v));
  endfunction

  task automatic frame_pulse(input int px, input int py, input bit f, input int idx, input bit h);
    pos_x = 10'(px); pos_y = 10'(py); facing_right = f; frame_idx = 6'(idx);
    frame_start = 1'b1; hit = h;
    @(posedge clk); #1;
    frame_start = 1'b0; hit = 1'b0;
    pos_x = 10'($urandom); pos_y = 10'($urandom);
    facing_right = 1'($urandom); frame_idx = 6'($urandom);
    m_act = (m_cnt != 0) && ((m_cnt / 2) % 2 == 1);
    if (h) m_cnt = 8;
    else if (m_cnt > 0) m_cnt = m_cnt - 1;
    m_px = px; m_py = py; m_face = f; m_idx = (idx >= 36) ? 0 : idx;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic hit_pulse();
    hit = 1'b1;
    @(posedge clk); #1;
    hit = 1'b0;
    m_cnt = 8;
  endtask

  // Drive one coordinate and sample the address and pixel it produces
  task automatic probe(input int h, input int v, output logic [19:0] a,
                       output logic on, output logic [11:0] rgb);
    hcount = 10'(h); vcount = 10'(v);
    repeat (2) begin @(posedge clk); #1; end
    a = rom_addr;
    repeat (LAT + 1) begin @(posedge clk); #1; end
    on = sprite_on; rgb = sprite_rgb;
  endtask

  task automatic test_reset();
    logic [19:0] a; logic on; logic [11:0] rgb;
    n_checks += 3;
    if (rom_addr !== 20'd0)    begin n_fail++; $display("FAIL rst_addr got %0d expected 0", rom_addr); end
    if (sprite_on !== 1'b0)    begin n_fail++; $display("FAIL rst_on got %b expected 0", sprite_on); end
    if (sprite_rgb !== 12'h0)  begin n_fail++; $display("FAIL rst_rgb got %h expected 000", sprite_rgb); end
    rst = 1'b0;
    rom_mode = 2;
    frame_pulse(0, 0, 1'b1, 0, 1'b0);
    probe(5, 5, a, on, rgb);
    n_checks += 2;
    if (on !== 1'b1)       begin n_fail++; $display("FAIL pre_rst_on got %b expected 1", on); end
    if (rgb !== 12'h0F0)   begin n_fail++; $display("FAIL pre_rst_rgb got %h expected 0f0", rgb); end
    // assert reset mid-cycle while the sprite covers the scan
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    n_checks += 3;
    if (sprite_on !== 1'b0)   begin n_fail++; $display("FAIL async_rst_on got %b expected 0", sprite_on); end
    if (sprite_rgb !== 12'h0) begin n_fail++; $display("FAIL async_rst_rgb got %h expected 000", sprite_rgb); end
    if (rom_addr !== 20'd0)   begin n_fail++; $display("FAIL async_rst_addr got %0d expected 0", rom_addr); end
    m_px = 0; m_py = 0; m_face = 1'b1; m_idx = 0; m_cnt = 0; m_act = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (sprite_on !== 1'b0) begin n_fail++; $display("FAIL early_on cycle %0d got %b expected 0", k, sprite_on); end
    end
    @(posedge clk); #1;
    n_checks++;
    if (sprite_on !== m_on(5, 5)) begin n_fail++; $display("FAIL first_valid_on got %b expected %b", sprite_on, m_on(5, 5)); end
    rom_mode = 0;
    frame_pulse(100, 50, 1'b1, 0, 1'b0);
    probe(100, 50, a, on, rgb);
    n_checks += 3;
    if (a !== 20'd0)              begin n_fail++; $display("FAIL post_rst_addr got %0d expected 0", a); end
    if (on !== 1'b1)              begin n_fail++; $display("FAIL post_rst_on got %b expected 1", on); end
    if (rgb !== rom_fn(0))        begin n_fail++; $display("FAIL post_rst_rgb got %h expected %h", rgb, rom_fn(0)); end
  endtask

  task automatic test_flip();
    logic [19:0] a; logic on; logic [11:0] rgb;
    int hs [4] = '{300, 301, 425, 360};
    int vs [4] = '{203, 200, 203, 325};
    rom_mode = 0;
    frame_pulse(300, 200, 1'b0, 2, 1'b0);
    probe(300, 203, a, on, rgb);
    n_checks++;
    if (a !== 20'd32255) begin n_fail++; $display("FAIL flip_addr got %0d expected 32255", a); end
    foreach (hs[i]) begin
      probe(hs[i], vs[i], a, on, rgb);
      n_checks += 3;
      if (a !== 20'(m_addr(hs[i], vs[i]))) begin n_fail++; $display("FAIL flip_addr%0d got %0d expected %0d", i, a, m_addr(hs[i], vs[i])); end
      if (on !== m_on(hs[i], vs[i]))       begin n_fail++; $display("FAIL flip_on%0d got %b expected %b", i, on, m_on(hs[i], vs[i])); end
      if (rgb !== m_rgb(hs[i], vs[i]))     begin n_fail++; $display("FAIL flip_rgb%0d got %h expected %h", i, rgb, m_rgb(hs[i], vs[i])); end
    end
  endtask

  task automatic test_midframe();
    logic [19:0] a; logic on; logic [11:0] rgb;
    int hs [2] = '{150, 250};
    frame_pulse(100, 50, 1'b1, 3, 1'b0);
    pos_x = 10'd200; frame_idx = 6'd5; facing_right = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) frame_pulse(200, 50, 1'b1, 5, 1'b0);
      foreach (hs[i]) begin
        probe(hs[i], 60, a, on, rgb);
        n_checks += 3;
        if (a !== 20'(m_addr(hs[i], 60))) begin n_fail++; $display("FAIL mid_addr p%0d h=%0d got %0d expected %0d", pass, hs[i], a, m_addr(hs[i], 60)); end
        if (on !== m_on(hs[i], 60))       begin n_fail++; $display("FAIL mid_on p%0d h=%0d got %b expected %b", pass, hs[i], on, m_on(hs[i], 60)); end
        if (rgb !== m_rgb(hs[i], 60))     begin n_fail++; $display("FAIL mid_rgb p%0d h=%0d got %h expected %h", pass, hs[i], rgb, m_rgb(hs[i], 60)); end
      end
    end
  endtask

  task automatic test_edge();
    logic [19:0] a; logic on; logic [11:0] rgb;
    int hs [8] = '{999, 1000, 1010, 1023, 0, 50, 101, 5};
    frame_pulse(1000, 0, 1'b1, 40, 1'b0);
    foreach (hs[i]) begin
      probe(hs[i], 10, a, on, rgb);
      n_checks += 3;
      if (a !== 20'(m_addr(hs[i], 10))) begin n_fail++; $display("FAIL edge_addr h=%0d got %0d expected %0d", hs[i], a, m_addr(hs[i], 10)); end
      if (on !== m_on(hs[i], 10))       begin n_fail++; $display("FAIL edge_on h=%0d got %b expected %b", hs[i], on, m_on(hs[i], 10)); end
      if (rgb !== m_rgb(hs[i], 10))     begin n_fail++; $display("FAIL edge_rgb h=%0d got %h expected %h", hs[i], rgb, m_rgb(hs[i], 10)); end
    end
  endtask

  task automatic test_colour_key();
    logic [19:0] a; logic on; logic [11:0] rgb;
    frame_pulse(400, 300, 1'b1, 7, 1'b0);
    rom_mode = 1;
    probe(410, 310, a, on, rgb);
    n_checks += 2;
    if (on !== 1'b0)      begin n_fail++; $display("FAIL key_on got %b expected 0", on); end
    if (rgb !== 12'h000)  begin n_fail++; $display("FAIL key_rgb got %h expected 000", rgb); end
    rom_mode = 2;
    probe(410, 310, a, on, rgb);
    n_checks += 2;
    if (on !== 1'b1)      begin n_fail++; $display("FAIL green_on got %b expected 1", on); end
    if (rgb !== 12'h0F0)  begin n_fail++; $display("FAIL green_rgb got %h expected 0f0", rgb); end
    rom_mode = 0;
  endtask

  task automatic test_flash();
    logic [19:0] a; logic on; logic [11:0] rgb;
    int hs [2] = '{1, 3};
    rom_mode = 0;
    frame_pulse(0, 0, 1'b1, 0, 1'b0);
    hit_pulse();
    for (int fr = 1; fr <= 14; fr++) begin
      frame_pulse(0, 0, 1'b1, 0, fr == 4);
      foreach (hs[i]) begin
        probe(hs[i], 0, a, on, rgb);
        n_checks += 2;
        if (on !== m_on(hs[i], 0))   begin n_fail++; $display("FAIL flash_on fr%0d h=%0d got %b expected %b", fr, hs[i], on, m_on(hs[i], 0)); end
        if (rgb !== m_rgb(hs[i], 0)) begin n_fail++; $display("FAIL flash_rgb fr%0d h=%0d got %h expected %h", fr, hs[i], rgb, m_rgb(hs[i], 0)); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] a; logic on; logic [11:0] rgb;
    int px, py, h, v;
    rom_mode = 0;
    for (int it = 0; it < 25; it++) begin
      px = $urandom_range(0, 1023);
      py = $urandom_range(0, 700);
      if ($urandom_range(0, 4) == 0) hit_pulse();
      frame_pulse(px, py, 1'($urandom), $urandom_range(0, 45), $urandom_range(0, 5) == 0);
      for (int j = 0; j < 3; j++) begin
        h = px + $urandom_range(0, 135) - 4; if (h < 0) h = 0; if (h > 1023) h = 1023;
        v = py + $urandom_range(0, 135) - 4; if (v < 0) v = 0; if (v > 1023) v = 1023;
        probe(h, v, a, on, rgb);
        n_checks += 3;
        if (a !== 20'(m_addr(h, v))) begin n_fail++; $display("FAIL rand_addr (%0d,%0d) got %0d expected %0d", h, v, a, m_addr(h, v)); end
        if (on !== m_on(h, v))       begin n_fail++; $display("FAIL rand_on (%0d,%0d) got %b expected %b", h, v, on, m_on(h, v)); end
        if (rgb !== m_rgb(h, v))     begin n_fail++; $display("FAIL rand_rgb (%0d,%0d) got %h expected %h", h, v, rgb, m_rgb(h, v)); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; hcount = '0; vcount = '0; frame_start = 1'b0; hit = 1'b0;
    pos_x = '0; pos_y = '0; facing_right = 1'b1; frame_idx = '0;
    rom_mode = 0;
    m_px = 0; m_py = 0; m_face = 1'b1; m_idx = 0; m_cnt = 0; m_act = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    test_reset();
    test_flip();
    test_midframe();
    test_edge();
    test_colour_key();
    test_flash();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
